instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of program memory entries (power of 2, 2..256).
REQ-002 SHALL have parameter OPW, default 19, meaning instruction width: operation[18:16], operand1[15:8], operand2[7:0].
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk (input, 1, sole clock, all state on rising edge) and rst (input, 1, synchronous active-high reset).
REQ-004 SHALL have load_en  input  1  program write strobe.
REQ-005 SHALL have load_addr  input  log2(DEPTH)  program write address.
REQ-006 SHALL have load_data  input  OPW  instruction to write.
REQ-007 SHALL have start  input  1  begin execution pulse.
REQ-008 SHALL have prog_len  input  log2(DEPTH)+1  number of instructions to run.
REQ-009 SHALL have opcode  output  OPW  instruction presented to the downstream CPU datapath.
REQ-010 SHALL have opcode_valid  output  1  opcode is valid this cycle.
REQ-011 SHALL have opcode_ready  input  1  downstream accepts opcode this cycle.
REQ-012 SHALL have cpu_result  input  8  combinational result returned by the CPU for the presented opcode.
REQ-013 SHALL have res_valid  output  1  one-cycle pulse, res_data/res_index updated.
REQ-014 SHALL have res_data  output  8  captured result.
REQ-015 SHALL have res_index  output  log2(DEPTH)  program index of captured result.
REQ-016 SHALL have busy  output  1  high in RUN.
REQ-017 SHALL have done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE; no other reachable states.
REQ-019 IDLE: load_en high SHALL write load_data to mem[load_addr] at the clock edge; load_en in RUN/DONE SHALL be ignored.
REQ-020 IDLE: start high with 1 <= prog_len SHALL latch len = min(prog_len, DEPTH), set pc=0, enter RUN next cycle.
REQ-021 IDLE: start with prog_len==0 SHALL be ignored (stay IDLE, no done pulse).
REQ-022 Same-cycle load_en and start in IDLE SHALL perform the write and then start; the written word is visible at pc 0 onward.
REQ-023 RUN: opcode SHALL equal mem[pc] combinationally; opcode_valid SHALL be 1; outside RUN opcode SHALL be 0 and opcode_valid 0.
REQ-024 Handshake: transfer occurs on a cycle where opcode_valid and opcode_ready are both 1; opcode SHALL remain stable while valid and not ready.
REQ-025 On transfer SHALL register res_data=cpu_result, res_index=pc, res_valid=1 for the next cycle only.
REQ-026 On transfer with pc != len-1 SHALL increment pc; with pc == len-1 SHALL enter DONE.
REQ-027 DONE: done SHALL be 1 for exactly one cycle, then FSM returns to IDLE; start in DONE SHALL be ignored.
REQ-028 start or prog_len changes during RUN SHALL have no effect.
REQ-029 Throughput: one instruction per cycle with opcode_ready held high; len instructions complete in len cycles of RUN.
REQ-030 busy SHALL be 1 exactly while in RUN.
REQ-031 pc SHALL never exceed DEPTH-1; no wrap-around within a run.

Reset
REQ-032 rst SHALL force IDLE, pc=0, len=0, opcode_valid=0, res_valid=0, res_data=0, res_index=0, busy=0, done=0 on the next edge.
REQ-033 rst SHALL take priority over start, load_en, and handshake in the same cycle.
REQ-034 rst during RUN SHALL abort the run with no further res_valid or done pulse.
REQ-035 Program memory SHALL NOT be cleared by rst.

Verification
REQ-036 Load mem[0]=19'h10305 (ADD 3,5), start, prog_len=1, ready=1, CPU model -> res_valid pulse with res_data=8'h08, res_index=0, then done pulse, busy low.
REQ-037 Load mem[0..2]={19'h20905 (SUB 9,5), 19'h3FF00 (INC FF), 19'h50F3C (AND 0F,3C)}, prog_len=3 -> res_data sequence 04, 00, 0C on consecutive cycles, indices 0,1,2.
REQ-038 RUN with opcode_ready low 4 cycles -> opcode and opcode_valid stable, no res_valid; ready high -> one capture.
REQ-039 Assert rst while pc=1 of a 3-instruction run -> IDLE next cycle, no done pulse; restart yields full correct sequence from pc 0 (memory retained).
REQ-040 start with prog_len=0 -> stays IDLE, no pulses; prog_len=DEPTH+5 -> exactly DEPTH results then done.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
// Groups the program-load, start, opcode handshake and result signals of
// instr_sequencer.
//   slave  : the sequencer (drives opcode/opcode_valid/res_*/busy/done)
//   master : the environment (program loader + CPU datapath)
// Signals:
//   load_en/load_addr/load_data : program memory write port
//   start/prog_len              : run request and instruction count
//   opcode/opcode_valid         : instruction presented to the CPU
//   opcode_ready/cpu_result     : CPU acceptance and combinational result
//   res_valid/res_data/res_index: captured result, one-cycle pulse
//   busy/done                   : run status and completion pulse
// ---------------------------------------------------------------------------
interface instr_sequencer_if #(
    parameter int DEPTH = 16,
    parameter int OPW   = 19
);
    localparam int AW = $clog2(DEPTH);

    logic           load_en;
    logic [AW-1:0]  load_addr;
    logic [OPW-1:0] load_data;
    logic           start;
    logic [AW:0]    prog_len;
    logic [OPW-1:0] opcode;
    logic           opcode_valid;
    logic           opcode_ready;
    logic [7:0]     cpu_result;
    logic           res_valid;
    logic [7:0]     res_data;
    logic [AW-1:0]  res_index;
    logic           busy;
    logic           done;

    modport slave (
        input  load_en, load_addr, load_data, start, prog_len,
               opcode_ready, cpu_result,
        output opcode, opcode_valid, res_valid, res_data, res_index,
               busy, done
    );

    modport master (
        output load_en, load_addr, load_data, start, prog_len,
               opcode_ready, cpu_result,
        input  opcode, opcode_valid, res_valid, res_data, res_index,
               busy, done
    );
endinterface

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Holds a small program memory, then on start streams len = min(prog_len,
// DEPTH) instructions to a CPU datapath over a valid/ready handshake,
// capturing the CPU's combinational result for each accepted instruction.
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset (memory contents retained)
//   bus : instr_sequencer_if.slave (load, start, opcode handshake, results)
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int OPW   = 19
) (
    input  logic              clk,
    input  logic              rst,
    instr_sequencer_if.slave  bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEN_ONE   = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state, next_state;
    logic [OPW-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]  pc;
    logic [AW:0]    len;
    logic           transfer;
    logic           last;
    logic           start_ok;

    always_comb begin
        transfer = (state == S_RUN) && bus.opcode_ready;
        last     = ({1'b0, pc} == (len - LEN_ONE));
        start_ok = bus.start && (bus.prog_len != '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start_ok) next_state = S_RUN;
            S_RUN:   if (transfer && last) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.opcode       = '0;
        bus.opcode_valid = 1'b0;
        bus.busy         = 1'b0;
        bus.done         = 1'b0;
        case (state)
            S_RUN: begin
                bus.opcode       = mem[pc];
                bus.opcode_valid = 1'b1;
                bus.busy         = 1'b1;
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    // Program memory: written only in IDLE, never cleared by reset. A write
    // in the start cycle lands before RUN reads it on the following cycle.
    always_ff @(posedge clk) begin
        if (!rst && state == S_IDLE && bus.load_en)
            mem[bus.load_addr] <= bus.load_data;
    end

    // Datapath: pc/len and captured result
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= '0;
            len           <= '0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_index <= '0;
        end else begin
            bus.res_valid <= transfer;
            if (transfer) begin
                bus.res_data  <= bus.cpu_result;
                bus.res_index <= pc;
                if (!last) pc <= pc + AW'(1);
            end
            if (state == S_IDLE && start_ok) begin
                pc  <= '0;
                len <= (bus.prog_len > DEPTH_LEN) ? DEPTH_LEN : bus.prog_len;
            end
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;
    localparam int DEPTH = 16;
    localparam int OPW   = 19;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    instr_sequencer_if #(.DEPTH(DEPTH), .OPW(OPW)) bus ();

    instr_sequencer #(.DEPTH(DEPTH), .OPW(OPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // CPU datapath model: 1=ADD 2=SUB 3=INC 5=AND
    always_comb begin
        case (bus.opcode[18:16])
            3'd1:    bus.cpu_result = bus.opcode[15:8] + bus.opcode[7:0];
            3'd2:    bus.cpu_result = bus.opcode[15:8] - bus.opcode[7:0];
            3'd3:    bus.cpu_result = bus.opcode[15:8] + 8'd1;
            3'd5:    bus.cpu_result = bus.opcode[15:8] & bus.opcode[7:0];
            default: bus.cpu_result = 8'h00;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] addr, input logic [18:0] data);
        bus.load_en   = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        tick();
        bus.load_en   = 1'b0;
    endtask

    // Runs the SUB/INC/AND program already held in mem[0..2]
    task automatic run3(input string tag);
        bus.start    = 1'b1;
        bus.prog_len = 5'd3;
        tick();
        bus.start    = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_op0"}, 32'(bus.opcode), 32'h20905);
        tick();
        check({tag, "_rv0"}, 32'(bus.res_valid), 32'd1);
        check({tag, "_rd0"}, 32'(bus.res_data), 32'h04);
        check({tag, "_ri0"}, 32'(bus.res_index), 32'd0);
        check({tag, "_op1"}, 32'(bus.opcode), 32'h3FF00);
        tick();
        check({tag, "_rd1"}, 32'(bus.res_data), 32'h00);
        check({tag, "_ri1"}, 32'(bus.res_index), 32'd1);
        check({tag, "_done_early"}, 32'(bus.done), 32'd0);
        tick();
        check({tag, "_rd2"}, 32'(bus.res_data), 32'h0C);
        check({tag, "_ri2"}, 32'(bus.res_index), 32'd2);
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
        tick();
        check({tag, "_done_clr"}, 32'(bus.done), 32'd0);
        check({tag, "_rv_clr"}, 32'(bus.res_valid), 32'd0);
    endtask

    initial begin
        bus.load_en      = 1'b0;
        bus.load_addr    = '0;
        bus.load_data    = '0;
        bus.start        = 1'b0;
        bus.prog_len     = '0;
        bus.opcode_ready = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_ovalid", 32'(bus.opcode_valid), 32'd0);
        check("rst_opcode", 32'(bus.opcode), 32'd0);
        check("rst_rvalid", 32'(bus.res_valid), 32'd0);
        check("rst_rdata", 32'(bus.res_data), 32'd0);
        check("rst_rindex", 32'(bus.res_index), 32'd0);

        // Single ADD 3,5
        load(4'd0, 19'h10305);
        bus.opcode_ready = 1'b1;
        bus.start        = 1'b1;
        bus.prog_len     = 5'd1;
        tick();
        bus.start = 1'b0;
        check("add_busy", 32'(bus.busy), 32'd1);
        check("add_ovalid", 32'(bus.opcode_valid), 32'd1);
        check("add_opcode", 32'(bus.opcode), 32'h10305);
        tick();
        check("add_rvalid", 32'(bus.res_valid), 32'd1);
        check("add_rdata", 32'(bus.res_data), 32'h08);
        check("add_rindex", 32'(bus.res_index), 32'd0);
        check("add_done", 32'(bus.done), 32'd1);
        check("add_busy_lo", 32'(bus.busy), 32'd0);
        tick();
        check("add_done_clr", 32'(bus.done), 32'd0);
        check("add_rvalid_clr", 32'(bus.res_valid), 32'd0);

        // Three-instruction program; mem[0] written in the start cycle
        load(4'd1, 19'h3FF00);
        load(4'd2, 19'h50F3C);
        bus.load_en   = 1'b1;
        bus.load_addr = 4'd0;
        bus.load_data = 19'h20905;
        run3("seq");

        // Back-pressure: ready low for 4 cycles; start/prog_len churn in RUN
        bus.opcode_ready = 1'b0;
        bus.start        = 1'b1;
        bus.prog_len     = 5'd1;
        tick();
        bus.prog_len = 5'd0;
        for (int i = 0; i < 4; i++) begin
            check("stall_opcode", 32'(bus.opcode), 32'h20905);
            check("stall_ovalid", 32'(bus.opcode_valid), 32'd1);
            check("stall_rvalid", 32'(bus.res_valid), 32'd0);
            bus.load_en   = 1'b1;
            bus.load_addr = 4'd0;
            bus.load_data = 19'h7FFFF;
            tick();
        end
        bus.load_en      = 1'b0;
        bus.start        = 1'b0;
        bus.opcode_ready = 1'b1;
        tick();
        check("stall_rvalid_go", 32'(bus.res_valid), 32'd1);
        check("stall_rdata", 32'(bus.res_data), 32'h04);
        check("stall_done", 32'(bus.done), 32'd1);
        tick();
        check("stall_one_capture", 32'(bus.res_valid), 32'd0);

        // Reset mid-run at pc=1, then restart from retained memory
        bus.start    = 1'b1;
        bus.prog_len = 5'd3;
        tick();
        bus.start = 1'b0;
        tick();
        check("abort_pc1_index", 32'(bus.res_index), 32'd0);
        check("abort_pc1_op", 32'(bus.opcode), 32'h3FF00);
        rst = 1'b1;
        bus.start = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_rvalid", 32'(bus.res_valid), 32'd0);
        check("abort_ovalid", 32'(bus.opcode_valid), 32'd0);
        tick();
        check("abort_no_done", 32'(bus.done), 32'd0);
        check("abort_no_rvalid", 32'(bus.res_valid), 32'd0);
        check("abort_idle", 32'(bus.busy), 32'd0);
        run3("restart");

        // prog_len = 0 is ignored
        bus.start    = 1'b1;
        bus.prog_len = 5'd0;
        tick();
        bus.start = 1'b0;
        check("len0_busy", 32'(bus.busy), 32'd0);
        tick();
        check("len0_done", 32'(bus.done), 32'd0);
        check("len0_rvalid", 32'(bus.res_valid), 32'd0);

        // prog_len = DEPTH+5 clamps to DEPTH; mem[i] = INC i
        for (int i = 0; i < DEPTH; i++)
            load(4'(i), {3'd3, 8'(i), 8'h00});
        bus.start    = 1'b1;
        bus.prog_len = 5'(DEPTH + 5);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            check("clamp_rvalid", 32'(bus.res_valid), 32'd1);
            check("clamp_rdata", 32'(bus.res_data), 32'(i + 1));
            check("clamp_rindex", 32'(bus.res_index), 32'(i));
            check("clamp_done", 32'(bus.done), (i == DEPTH - 1) ? 32'd1 : 32'd0);
        end
        tick();
        check("clamp_end_busy", 32'(bus.busy), 32'd0);
        check("clamp_end_rvalid", 32'(bus.res_valid), 32'd0);
        check("clamp_end_done", 32'(bus.done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
